// File: rtl/icache_pkg.sv
// Shared types, geometry and helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned ADDR_WIDTH   = 32;
    localparam int unsigned INDEX_WIDTH  = 6;
    localparam int unsigned OFFSET_WIDTH = 2;
    localparam int unsigned TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH - 2;
    localparam int unsigned LINES        = 1 << INDEX_WIDTH;
    localparam int unsigned LINE_WORDS   = 1 << OFFSET_WIDTH;

    // Bit positions of the address fields (byte address, bits[1:0] ignored)
    localparam int unsigned WORD_LSB  = 2;
    localparam int unsigned INDEX_LSB = OFFSET_WIDTH + 2;
    localparam int unsigned TAG_LSB   = ADDR_WIDTH - TAG_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_REFILL  = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    // True when the refill counter points at the final word of a line
    function automatic logic is_last_word(input logic [OFFSET_WIDTH-1:0] cnt);
        return (cnt == {OFFSET_WIDTH{1'b1}});
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// Reads are combinational; word writes, tag installs and the global clear are synchronous.
module icache_line_array
    import icache_pkg::*;
(
    input  logic                    clk,
    input  logic                    clr_all,
    input  logic [INDEX_WIDTH-1:0]  rd_index,
    input  logic [OFFSET_WIDTH-1:0] rd_word,
    output logic [TAG_WIDTH-1:0]    rd_tag,
    output logic                    rd_valid,
    output logic [31:0]             rd_data,
    input  logic                    wr_en,
    input  logic [INDEX_WIDTH-1:0]  wr_index,
    input  logic [OFFSET_WIDTH-1:0] wr_word,
    input  logic [31:0]             wr_data,
    input  logic                    set_en,
    input  logic [INDEX_WIDTH-1:0]  set_index,
    input  logic [TAG_WIDTH-1:0]    set_tag
);

    logic [LINES-1:0]     valid_r;
    logic [TAG_WIDTH-1:0] tag_mem_r  [LINES];
    logic [31:0]          data_mem_r [LINES*LINE_WORDS];

    assign rd_valid = valid_r[rd_index];
    assign rd_tag   = tag_mem_r[rd_index];
    assign rd_data  = data_mem_r[{rd_index, rd_word}];

    // Valid bits: cleared together, set one line at a time when a refill completes
    always_ff @(posedge clk) begin
        if (clr_all) begin
            valid_r <= {LINES{1'b0}};
        end else if (set_en) begin
            valid_r[set_index] <= 1'b1;
        end
    end

    // Tag store: written when a refilled line becomes valid
    always_ff @(posedge clk) begin
        if (set_en) begin
            tag_mem_r[set_index] <= set_tag;
        end
    end

    // Data store: one word per memory acknowledge during a refill
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem_r[{wr_index, wr_word}] <= wr_data;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: FSM, latched request address,
// refill word counter and memory request registers around the line array.
module icache
    import icache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        valid_from_fetcher,
    input  logic [31:0] addr_from_fetcher,
    output logic        next_cycle_ready_to_fetcher,
    output logic [31:0] data_to_fetcher,
    output logic        valid_to_mem_ctrl,
    output logic [31:0] addr_to_mem_ctrl,
    input  logic        ready_from_mem_ctrl,
    input  logic [31:0] data_from_mem_ctrl
);

    state_t                  state_r,     state_nxt;
    logic [31:0]             req_addr_r,  req_addr_nxt;
    logic [OFFSET_WIDTH-1:0] cnt_r,       cnt_nxt;
    logic                    mem_valid_r, mem_valid_nxt;
    logic [31:0]             mem_addr_r,  mem_addr_nxt;
    logic                    ncr_r,       ncr_nxt;
    logic [31:0]             data_r,      data_nxt;

    logic                    wr_word_s;
    logic                    set_line_s;
    logic                    hit_s;
    logic [TAG_WIDTH-1:0]    rd_tag_s;
    logic                    rd_valid_s;
    logic [31:0]             rd_data_s;
    logic [INDEX_WIDTH-1:0]  req_index_s;
    logic [OFFSET_WIDTH-1:0] req_word_s;
    logic [TAG_WIDTH-1:0]    req_tag_s;
    logic [31:0]             line_base_s;
    logic                    unused_byte_bits_s;

    assign req_tag_s          = req_addr_r[ADDR_WIDTH-1:TAG_LSB];
    assign req_index_s        = req_addr_r[INDEX_LSB+INDEX_WIDTH-1:INDEX_LSB];
    assign req_word_s         = req_addr_r[WORD_LSB+OFFSET_WIDTH-1:WORD_LSB];
    assign line_base_s        = {req_addr_r[ADDR_WIDTH-1:INDEX_LSB], {INDEX_LSB{1'b0}}};
    assign unused_byte_bits_s = ^req_addr_r[1:0];

    assign hit_s = rd_valid_s && (rd_tag_s == req_tag_s);

    assign next_cycle_ready_to_fetcher = ncr_r;
    assign data_to_fetcher             = data_r;
    assign valid_to_mem_ctrl           = mem_valid_r;
    assign addr_to_mem_ctrl            = mem_addr_r;

    icache_line_array u_lines (
        .clk       (clk),
        .clr_all   (rst),
        .rd_index  (req_index_s),
        .rd_word   (req_word_s),
        .rd_tag    (rd_tag_s),
        .rd_valid  (rd_valid_s),
        .rd_data   (rd_data_s),
        .wr_en     (wr_word_s && rdy && !rst),
        .wr_index  (req_index_s),
        .wr_word   (cnt_r),
        .wr_data   (data_from_mem_ctrl),
        .set_en    (set_line_s && rdy && !rst),
        .set_index (req_index_s),
        .set_tag   (req_tag_s)
    );

    // Next-state and next-register values; every register holds unless its state says otherwise
    always_comb begin
        state_nxt     = state_r;
        req_addr_nxt  = req_addr_r;
        cnt_nxt       = cnt_r;
        mem_valid_nxt = mem_valid_r;
        mem_addr_nxt  = mem_addr_r;
        ncr_nxt       = ncr_r;
        data_nxt      = data_r;
        wr_word_s     = 1'b0;
        set_line_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (valid_from_fetcher) begin
                    req_addr_nxt = addr_from_fetcher;
                    state_nxt    = ST_LOOKUP;
                end else begin
                    state_nxt    = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (hit_s) begin
                    ncr_nxt       = 1'b1;
                    state_nxt     = ST_RESPOND;
                end else begin
                    mem_valid_nxt = 1'b1;
                    mem_addr_nxt  = line_base_s;
                    cnt_nxt       = {OFFSET_WIDTH{1'b0}};
                    state_nxt     = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (ready_from_mem_ctrl) begin
                    wr_word_s    = 1'b1;
                    cnt_nxt      = cnt_r + 1'b1;
                    mem_addr_nxt = mem_addr_r + 32'd4;
                    if (is_last_word(cnt_r)) begin
                        mem_valid_nxt = 1'b0;
                        set_line_s    = 1'b1;
                        state_nxt     = ST_LOOKUP;
                    end else begin
                        state_nxt     = ST_REFILL;
                    end
                end else begin
                    state_nxt = ST_REFILL;
                end
            end
            ST_RESPOND: begin
                ncr_nxt  = 1'b0;
                data_nxt = rd_data_s;
                if (valid_from_fetcher) begin
                    req_addr_nxt = addr_from_fetcher;
                    state_nxt    = ST_LOOKUP;
                end else begin
                    state_nxt    = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers: synchronous reset, frozen while rdy is low
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            req_addr_r  <= 32'd0;
            cnt_r       <= {OFFSET_WIDTH{1'b0}};
            mem_valid_r <= 1'b0;
            mem_addr_r  <= 32'd0;
            ncr_r       <= 1'b0;
            data_r      <= 32'd0;
        end else if (rdy) begin
            state_r     <= state_nxt;
            req_addr_r  <= req_addr_nxt;
            cnt_r       <= cnt_nxt;
            mem_valid_r <= mem_valid_nxt;
            mem_addr_r  <= mem_addr_nxt;
            ncr_r       <= ncr_nxt;
            data_r      <= data_nxt;
        end
    end

endmodule
